// File: rtl/e203_icb_stub_slave.sv
// ICB stub target: small scratch register file behind an address window, with
// programmable response latency and an in-order outstanding-response queue.
module e203_icb_stub_slave #(
   parameter int             AW        = 32,
   parameter int             DW        = 32,
   parameter int             DEPTH     = 4,
   parameter int             LAT       = 2,
   parameter int             MEM_WORDS = 16,
   parameter logic [AW-1:0]  WIN_BASE  = 32'h1000_0000,
   parameter logic [AW-1:0]  WIN_MASK  = 32'h0000_003F
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         icb_cmd_valid,
   output logic                         icb_cmd_ready,
   input  logic [AW-1:0]                icb_cmd_addr,
   input  logic                         icb_cmd_read,
   input  logic [DW-1:0]                icb_cmd_wdata,
   input  logic [DW/8-1:0]              icb_cmd_wmask,
   output logic                         icb_rsp_valid,
   input  logic                         icb_rsp_ready,
   output logic                         icb_rsp_err,
   output logic [DW-1:0]                icb_rsp_rdata,
   output logic [$clog2(DEPTH+1)-1:0]   outstanding
);

   localparam int BW = DW/8;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = $clog2(MEM_WORDS);
   localparam int OW = $clog2(BW);

   typedef struct packed {
      logic          vld;
      logic          err;
      logic [DW-1:0] rdata;
      logic [3:0]    cnt;
   } ent_t;

   ent_t          ent_q [DEPTH];
   ent_t          ent_d [DEPTH];
   logic [DW-1:0] mem_q [MEM_WORDS];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          full, empty, acc, pop, hit;
   logic [IW-1:0] idx;

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign hit   = ((icb_cmd_addr & ~WIN_MASK) == WIN_BASE);
   assign idx   = icb_cmd_addr[OW +: IW];

   // Ready depends only on registered count, so a pop never frees a slot same-cycle.
   assign icb_cmd_ready = !full;
   assign acc           = icb_cmd_valid & icb_cmd_ready;
   assign icb_rsp_valid = !empty && (ent_q[rptr_q].cnt == 4'd0);
   assign pop           = icb_rsp_valid & icb_rsp_ready;
   assign icb_rsp_err   = icb_rsp_valid & ent_q[rptr_q].err;
   assign icb_rsp_rdata = icb_rsp_valid ? ent_q[rptr_q].rdata : '0;
   assign outstanding   = cnt_q;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
         // Younger entries keep counting down even while the head is stalled.
         if (ent_q[i].vld && ent_q[i].cnt != 4'd0)
            ent_d[i].cnt = ent_q[i].cnt - 4'd1;
      end
      if (pop)
         ent_d[rptr_q].vld = 1'b0;
      if (acc) begin
         ent_d[wptr_q].vld   = 1'b1;
         ent_d[wptr_q].err   = !hit;
         ent_d[wptr_q].rdata = (hit && icb_cmd_read) ? mem_q[idx] : '0;
         ent_d[wptr_q].cnt   = 4'(LAT);
      end
      wptr_d = wptr_q + PW'(acc);
      rptr_d = rptr_q + PW'(pop);
      cnt_d  = cnt_q + CW'(acc) - CW'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
      end else if (acc && hit && !icb_cmd_read) begin
         for (int b = 0; b < BW; b++)
            if (icb_cmd_wmask[b]) mem_q[idx][b*8 +: 8] <= icb_cmd_wdata[b*8 +: 8];
      end
   end

endmodule

// File: doc/e203_icb_stub_slave.md
Name: e203_icb_stub_slave

Overview:
- Parametrised ICB target that terminates an unused subsystem ICB port (sysper/sysfio/sysmem); replaces the zero-latency loopback tie-off.
- Adds a small word-addressed scratch register file, an address-window error check, programmable response latency and a multi-entry outstanding-response queue.
- Bring-up software can probe the port, and the bench can stress core-side ICB backpressure and error handling.

Parameters:
- AW, 32, ICB address width.
- DW, 32, ICB data width; wmask width is DW/8.
- DEPTH, 4, outstanding-response queue entries, power of two, at least 2.
- LAT, 2, extra response latency in cycles, 0..15.
- MEM_WORDS, 16, scratch words, power of two.
- WIN_BASE, 32'h1000_0000, window base address, aligned to the window size.
- WIN_MASK, 32'h0000_003F, in-window offset bits; must equal MEM_WORDS*DW/8-1.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; asynchronous, active-low.
- icb_cmd_valid  in  1  command valid.
- icb_cmd_ready  out  1  command ready.
- icb_cmd_addr  in  AW  byte address.
- icb_cmd_read  in  1  1=read, 0=write.
- icb_cmd_wdata  in  DW  write data.
- icb_cmd_wmask  in  DW/8  byte enables.
- icb_rsp_valid  out  1  response valid.
- icb_rsp_ready  in  1  response ready.
- icb_rsp_err  out  1  response error.
- icb_rsp_rdata  out  DW  read data.
- outstanding  out  $clog2(DEPTH+1)  queued response count.

Behaviour:
- Reset (async assert, sync release by the upstream reset tree):
  - queue pointers, count and all entry countdowns = 0.
  - scratch words = 0.
  - icb_rsp_valid = 0, icb_rsp_err = 0, icb_rsp_rdata = 0, outstanding = 0.
  - icb_cmd_ready = 1 once out of reset.
- Command handshake:
  - icb_cmd_ready = !full. No same-cycle bypass: when full, a pop in the same cycle does not raise ready; ready rises the cycle after the pop.
  - Accept = icb_cmd_valid & icb_cmd_ready.
- Window decode:
  - hit = ((icb_cmd_addr & ~WIN_MASK) == WIN_BASE).
  - index = addr[$clog2(DW/8) +: $clog2(MEM_WORDS)]; low byte-offset bits ignored.
- On accept:
  - Write with hit: each scratch byte whose wmask bit is set is updated at the accepting edge.
  - Read with hit: the current word is captured into the entry. A read accepted after a write returns the written data. Captured data does not change if a later write hits the same word.
  - Miss: no scratch update; the entry stores err=1, rdata=0.
  - Write responses always carry rdata=0.
  - The entry is pushed with countdown=LAT.
- Every cycle, each valid entry with a nonzero countdown decrements by 1.
- Response side:
  - icb_rsp_valid = !empty & (head countdown == 0).
  - rdata/err are driven from the head entry (registered storage, no combinational path from cmd to rsp).
  - Pop = icb_rsp_valid & icb_rsp_ready.
  - Responses return strictly in acceptance order.
- Latency: a command accepted at edge N has its response valid from cycle N+1+LAT at the earliest. Head-of-line stalls do not stop countdowns of younger entries, so back-to-back commands can respond on consecutive cycles.
- Stall: while icb_rsp_valid=1 and icb_rsp_ready=0, icb_rsp_valid/err/rdata hold stable.
- outstanding = count; +1 on accept, -1 on pop, unchanged if both happen in the same cycle.
- Pointers wrap modulo DEPTH. Full/empty come from the count, not from pointer equality.
- Reset mid-operation: all queued responses are dropped, scratch contents are cleared, and icb_rsp_valid falls immediately with rst_n.

Test Plan:
- Write 0x1000_0004, wdata 0xA5A5_1234, wmask 4'b1111, then read 0x1000_0004 → read rsp_valid exactly 3 cycles after its accept; rdata 0xA5A5_1234, err 0.
- Partial write to 0x1000_0008, wmask 4'b0010, wdata 0x0000_CD00, then read → rdata 0x0000_CD00; other bytes remain 0.
- Read 0x2000_0000 (outside the window) → err 1, rdata 0. Write to 0x2000_0000 → err 1; a scratch dump shows no change.
- icb_rsp_ready=0 with 5 back-to-back commands → exactly 4 accepted, outstanding=4, icb_cmd_ready=0. Raise ready → 4 in-order responses on consecutive cycles, and icb_cmd_ready rises the cycle after the first pop.
- Toggle icb_rsp_ready randomly for 1000 random commands → rsp order, data and err match the reference model; outstanding never exceeds 4.
- Assert rst_n=0 with 3 entries queued → icb_rsp_valid=0 and outstanding=0 immediately. After release, reading 0x1000_0004 returns 0.
